// File: rtl/instruction_mem_pipe.sv
// Word-indexed instruction RAM with an independent fetch port and program-load port,
// a post-reset zero-fill sequencer and a 1- or 2-cycle registered read pipeline.
module instruction_mem_pipe #(
    parameter int INSTRUCTION_WIDTH = 19,
    parameter int ADDRESS_BUS_WIDTH = 10,
    parameter int DEPTH             = 128,
    parameter int ADDR_SHIFT        = 2,
    parameter int READ_LATENCY      = 1,
    parameter int CLEAR_ON_RESET    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rd_req,
    input  logic [ADDRESS_BUS_WIDTH-1:0] rd_addr,
    output logic                         rd_valid,
    output logic [INSTRUCTION_WIDTH-1:0] rd_data,
    output logic                         rd_err,
    input  logic                         wr_en,
    input  logic [ADDRESS_BUS_WIDTH-1:0] wr_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] wr_data,
    output logic                         wr_ack,
    output logic                         busy
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [0:0] INIT_ST  = (CLEAR_ON_RESET != 0) ? ST_FILL : ST_READY;
    localparam logic [ADDRESS_BUS_WIDTH:0] DEPTH_L = (ADDRESS_BUS_WIDTH + 1)'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    logic [INSTRUCTION_WIDTH-1:0] mem_q [DEPTH];

    logic [0:0]                   state_q, state_d;
    logic [IW-1:0]                fill_q, fill_d;
    logic                         busy_q;
    logic                         fill_we_s;
    logic [ADDRESS_BUS_WIDTH-1:0] rd_idx_s, wr_idx_s;
    logic                         rd_in_range_s, wr_in_range_s;
    logic                         rd_accept_s, wr_accept_s;

    logic                         s1_valid_q;
    logic [INSTRUCTION_WIDTH-1:0] s1_data_q;
    logic                         s1_err_q;
    logic                         wr_ack_q;

    // Index decode and port acceptance; both ports are gated off while filling.
    always_comb begin
        rd_idx_s      = rd_addr >> ADDR_SHIFT;
        wr_idx_s      = wr_addr >> ADDR_SHIFT;
        rd_in_range_s = ({1'b0, rd_idx_s} < DEPTH_L);
        wr_in_range_s = ({1'b0, wr_idx_s} < DEPTH_L);
        rd_accept_s   = rd_req && (state_q == ST_READY);
        wr_accept_s   = wr_en && (state_q == ST_READY);
    end

    // Fill sequencer next-state: one zero word per cycle, then READY forever.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        fill_we_s = 1'b0;
        case (state_q)
            ST_FILL: begin
                fill_we_s = 1'b1;
                if (fill_q == LAST_IDX) begin
                    state_d = ST_READY;
                    fill_d  = '0;
                end else begin
                    state_d = ST_FILL;
                    fill_d  = fill_q + IW'(1);
                end
            end
            ST_READY: begin
                state_d = ST_READY;
                fill_d  = fill_q;
            end
            default: begin
                state_d = INIT_ST;
                fill_d  = '0;
            end
        endcase
    end

    // Sequencer state and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT_ST;
            fill_q  <= '0;
            busy_q  <= (INIT_ST == ST_FILL);
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            busy_q  <= (state_d == ST_FILL);
        end
    end

    // Storage array; out-of-range loads are dropped rather than aliased.
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            mem_q[fill_q] <= '0;
        end else if (wr_accept_s && wr_in_range_s) begin
            mem_q[wr_idx_s[IW-1:0]] <= wr_data;
        end
    end

    // First read stage samples the array at acceptance, giving read-first collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_err_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
        end else begin
            s1_valid_q <= rd_accept_s;
            wr_ack_q   <= wr_accept_s;
            if (rd_accept_s) begin
                s1_data_q <= rd_in_range_s ? mem_q[rd_idx_s[IW-1:0]] : '0;
                s1_err_q  <= !rd_in_range_s;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                         s2_valid_q;
            logic [INSTRUCTION_WIDTH-1:0] s2_data_q;
            logic                         s2_err_q;

            // Extra output stage; data/err only move when a result passes through.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                    s2_err_q   <= 1'b0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                        s2_err_q  <= s1_err_q;
                    end
                end
            end

            assign rd_valid = s2_valid_q;
            assign rd_data  = s2_data_q;
            assign rd_err   = s2_err_q;
        end else begin : g_lat1
            assign rd_valid = s1_valid_q;
            assign rd_data  = s1_data_q;
            assign rd_err   = s1_err_q;
        end
    endgenerate

    assign wr_ack = wr_ack_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_instruction_mem_pipe.sv
// Scoreboard bench: latency-1 and latency-2 instances share all stimulus; a bench-side
// memory model predicts every fetch result and write acknowledge.
module tb_instruction_mem_pipe;

    logic        clk;
    logic        rst_n;
    logic        rd_req;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [18:0] wr_data;

    logic        rd_valid1, rd_err1, wr_ack1, busy1;
    logic [18:0] rd_data1;
    logic        rd_valid2, rd_err2, wr_ack2, busy2;
    logic [18:0] rd_data2;

    typedef struct {
        int          due;
        logic [18:0] data;
        logic        err;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    int          ack1[$];
    int          ack2[$];
    logic [18:0] mem_m [128];
    int          cyc;
    int          n_cmp;
    int          n_err;
    logic        accepting;

    instruction_mem_pipe #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_err(rd_err1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack1), .busy(busy1)
    );

    instruction_mem_pipe #(.READ_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid2), .rd_data(rd_data2), .rd_err(rd_err2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop an expectation whenever a DUT produces a result or it falls due.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (rd_valid1 === 1'b1) begin
                    n_cmp++;
                    if (q1.size() == 0) begin
                        n_err++;
                        $display("FAIL lat1_unexpected_valid: rd_valid=1 at cycle %0d, required 0", cyc);
                    end else begin
                        e = q1.pop_front();
                        if (e.due != cyc || rd_data1 !== e.data || rd_err1 !== e.err) begin
                            n_err++;
                            $display("FAIL lat1_read: got data=%h err=%b cycle=%0d, required data=%h err=%b cycle=%0d",
                                     rd_data1, rd_err1, cyc, e.data, e.err, e.due);
                        end
                    end
                end else if (q1.size() != 0 && q1[0].due <= cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL lat1_missing_valid: rd_valid=%b at cycle %0d, required 1", rd_valid1, cyc);
                    void'(q1.pop_front());
                end

                if (rd_valid2 === 1'b1) begin
                    n_cmp++;
                    if (q2.size() == 0) begin
                        n_err++;
                        $display("FAIL lat2_unexpected_valid: rd_valid=1 at cycle %0d, required 0", cyc);
                    end else begin
                        e = q2.pop_front();
                        if (e.due != cyc || rd_data2 !== e.data || rd_err2 !== e.err) begin
                            n_err++;
                            $display("FAIL lat2_read: got data=%h err=%b cycle=%0d, required data=%h err=%b cycle=%0d",
                                     rd_data2, rd_err2, cyc, e.data, e.err, e.due);
                        end
                    end
                end else if (q2.size() != 0 && q2[0].due <= cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL lat2_missing_valid: rd_valid=%b at cycle %0d, required 1", rd_valid2, cyc);
                    void'(q2.pop_front());
                end

                if (wr_ack1 === 1'b1) begin
                    n_cmp++;
                    if (ack1.size() == 0 || ack1[0] != cyc) begin
                        n_err++;
                        $display("FAIL lat1_wr_ack: wr_ack=1 at cycle %0d, required none", cyc);
                    end
                    if (ack1.size() != 0 && ack1[0] <= cyc) void'(ack1.pop_front());
                end else if (ack1.size() != 0 && ack1[0] <= cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL lat1_wr_ack_missing: wr_ack=%b at cycle %0d, required 1", wr_ack1, cyc);
                    void'(ack1.pop_front());
                end

                if (wr_ack2 === 1'b1) begin
                    n_cmp++;
                    if (ack2.size() == 0 || ack2[0] != cyc) begin
                        n_err++;
                        $display("FAIL lat2_wr_ack: wr_ack=1 at cycle %0d, required none", cyc);
                    end
                    if (ack2.size() != 0 && ack2[0] <= cyc) void'(ack2.pop_front());
                end else if (ack2.size() != 0 && ack2[0] <= cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL lat2_wr_ack_missing: wr_ack=%b at cycle %0d, required 1", wr_ack2, cyc);
                    void'(ack2.pop_front());
                end
            end
        end
    end

    // Drive one cycle of stimulus, predicting results with read-before-write ordering.
    task automatic drive(input logic rd, input logic [9:0] ra, input logic wr,
                         input logic [9:0] wa, input logic [18:0] wd);
        exp_t       e;
        logic [9:0] ri;
        logic [9:0] wi;
        rd_req  = rd;
        rd_addr = ra;
        wr_en   = wr;
        wr_addr = wa;
        wr_data = wd;
        ri = ra >> 2;
        wi = wa >> 2;
        if (accepting) begin
            if (rd) begin
                e.err  = (ri >= 10'd128);
                e.data = e.err ? 19'h0 : mem_m[ri[6:0]];
                e.due  = cyc + 1;
                q1.push_back(e);
                e.due  = cyc + 2;
                q2.push_back(e);
            end
            if (wr) begin
                ack1.push_back(cyc + 1);
                ack2.push_back(cyc + 1);
                if (wi < 10'd128) mem_m[wi[6:0]] = wd;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 10'h000, 1'b0, 10'h000, 19'h0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rd_req    = 1'b0;
        wr_en     = 1'b0;
        accepting = 1'b0;
        q1.delete();
        q2.delete();
        ack1.delete();
        ack2.delete();
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({rd_valid1, rd_data1, rd_err1, wr_ack1, busy1} !== {1'b0, 19'h0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state_lat1: got valid=%b data=%h err=%b ack=%b busy=%b, required 0/00000/0/0/1",
                     rd_valid1, rd_data1, rd_err1, wr_ack1, busy1);
        end
        n_cmp++;
        if ({rd_valid2, rd_data2, rd_err2, wr_ack2, busy2} !== {1'b0, 19'h0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state_lat2: got valid=%b data=%h err=%b ack=%b busy=%b, required 0/00000/0/0/1",
                     rd_valid2, rd_data2, rd_err2, wr_ack2, busy2);
        end
        rst_n = 1'b1;
    endtask

    // Reset, count busy cycles while hammering both ports, then fetch the last word.
    task automatic test_reset();
        int cnt;
        do_reset();
        rd_req  = 1'b1;
        rd_addr = 10'h1FC;
        wr_en   = 1'b1;
        wr_addr = 10'h1FC;
        wr_data = 19'h7FFFF;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy1 !== 1'b1) break;
            cnt++;
            @(negedge clk);
        end
        rd_req = 1'b0;
        wr_en  = 1'b0;
        n_cmp++;
        if (cnt != 128) begin
            n_err++;
            $display("FAIL fill_busy_cycles: got %0d, required 128", cnt);
        end
        n_cmp++;
        if (busy2 !== 1'b0) begin
            n_err++;
            $display("FAIL fill_busy_lat2: got busy=%b, required 0", busy2);
        end
        for (int i = 0; i < 128; i++) mem_m[i] = 19'h0;
        accepting = 1'b1;
        drive(1'b1, 10'h1FC, 1'b0, 10'h000, 19'h0);
        idle(3);
    endtask

    task automatic test_load_fetch();
        drive(1'b0, 10'h000, 1'b1, 10'h000, 19'h21010);
        drive(1'b0, 10'h000, 1'b1, 10'h004, 19'h22014);
        drive(1'b0, 10'h000, 1'b1, 10'h008, 19'h07600);
        drive(1'b0, 10'h000, 1'b1, 10'h00C, 19'h24830);
        drive(1'b1, 10'h000, 1'b0, 10'h000, 19'h0);
        drive(1'b1, 10'h004, 1'b0, 10'h000, 19'h0);
        drive(1'b1, 10'h008, 1'b0, 10'h000, 19'h0);
        drive(1'b1, 10'h00C, 1'b0, 10'h000, 19'h0);
        idle(3);
    endtask

    task automatic test_range();
        drive(1'b1, 10'h3FC, 1'b0, 10'h000, 19'h0);
        drive(1'b0, 10'h000, 1'b1, 10'h200, 19'h01234);
        drive(1'b1, 10'h000, 1'b0, 10'h000, 19'h0);
        idle(3);
    endtask

    // Same-index read and write in one cycle, then hold of the last result.
    task automatic test_collision();
        drive(1'b0, 10'h000, 1'b1, 10'h014, 19'h11111);
        drive(1'b1, 10'h014, 1'b1, 10'h014, 19'h22222);
        drive(1'b1, 10'h014, 1'b0, 10'h000, 19'h0);
        idle(3);
        n_cmp++;
        if (rd_valid1 !== 1'b0 || rd_data1 !== 19'h22222) begin
            n_err++;
            $display("FAIL hold_lat1: got valid=%b data=%h, required 0/22222", rd_valid1, rd_data1);
        end
        n_cmp++;
        if (rd_valid2 !== 1'b0 || rd_data2 !== 19'h22222) begin
            n_err++;
            $display("FAIL hold_lat2: got valid=%b data=%h, required 0/22222", rd_valid2, rd_data2);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] ra;
        logic [9:0] wa;
        for (int i = 0; i < 150; i++) begin
            ra = 10'($urandom_range(0, 639));
            wa = ($urandom_range(0, 1) == 0) ? ra : 10'($urandom_range(0, 639));
            drive(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, 19'($urandom));
        end
        idle(3);
        n_cmp++;
        if (q1.size() != 0 || q2.size() != 0 || ack1.size() != 0 || ack2.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d/%0d/%0d outstanding, required 0", q1.size(), q2.size(),
                     ack1.size(), ack2.size());
        end
    endtask

    // Reset with a fetch in flight, then reset again 60 cycles into the fill.
    task automatic test_mid_reset();
        drive(1'b0, 10'h000, 1'b1, 10'h000, 19'h12345);
        rd_req  = 1'b1;
        rd_addr = 10'h000;
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 60; i++) @(negedge clk);
        n_cmp++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
            n_err++;
            $display("FAIL mid_fill_busy: got %b/%b, required 1/1", busy1, busy2);
        end
        test_reset();
        drive(1'b1, 10'h000, 1'b0, 10'h000, 19'h0);
        idle(3);
    endtask

    initial begin
        rst_n     = 1'b0;
        rd_req    = 1'b0;
        rd_addr   = 10'h000;
        wr_en     = 1'b0;
        wr_addr   = 10'h000;
        wr_data   = 19'h0;
        accepting = 1'b0;
        cyc       = 0;
        n_cmp     = 0;
        n_err     = 0;
        @(negedge clk);
        test_reset();
        test_load_fetch();
        test_range();
        test_collision();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
